// File: rtl/native_bus_pkg.sv
// ----------------------------------------------------------------------------
// native_bus_pkg
//   Shared definitions for the native valid/ready core bus: bus widths and
//   the responder state encoding.
// ----------------------------------------------------------------------------
package native_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } resp_state_e;

endpackage : native_bus_pkg

// File: rtl/native_ram_array.sv
// ----------------------------------------------------------------------------
// native_ram_array
//   Single-port synchronous word RAM with per-byte write enables and a
//   registered read port. Contents are not reset.
//
// Ports
//   clk    in   clock
//   we     in   write enable (byte lanes selected by be)
//   re     in   read enable; rdata updates on the following edge
//   be     in   byte enables, one per 8-bit lane
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data
// ----------------------------------------------------------------------------
module native_ram_array
    import native_bus_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [BUS_SW-1:0] be,
    input  logic [AW-1:0]     idx,
    input  logic [BUS_DW-1:0] wdata,
    output logic [BUS_DW-1:0] rdata
);

    logic [BUS_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BUS_SW; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        // read/write never target the same cycle: the read is issued the
        // cycle before the response, the write happens in the response cycle
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule : native_ram_array

// File: rtl/native_ram_resp.sv
// ----------------------------------------------------------------------------
// native_ram_resp
//   Responder end of the native valid/ready core bus. Decodes a word-addressed
//   window, inserts WAIT_CYC wait states, performs a strobe-merged write or a
//   read, and returns a one-cycle ready pulse followed by a turnaround cycle.
//   Out-of-window accesses complete normally (write dropped, read data 0) and
//   set a sticky error flag that remembers the first offending address.
//
// Ports
//   clk_i         in   system clock
//   rst_i         in   synchronous active-high reset
//   core_valid_i  in   request valid, held until ready
//   core_addr_i   in   byte address, bits [1:0] ignored
//   core_wdata_i  in   write data
//   core_wstrb_i  in   byte strobes, 4'b0000 = read
//   core_rdata_o  out  read data, zero whenever ready is low
//   core_ready_o  out  one-cycle completion pulse
//   err_o         out  sticky out-of-window flag
//   err_addr_o    out  address of first errored access since last clear
//   err_clr_i     in   clears err_o / err_addr_o (a coincident error wins)
// ----------------------------------------------------------------------------
module native_ram_resp
    import native_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          WAIT_CYC  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_valid_i,
    input  logic [BUS_AW-1:0] core_addr_i,
    input  logic [BUS_DW-1:0] core_wdata_i,
    input  logic [BUS_SW-1:0] core_wstrb_i,
    output logic [BUS_DW-1:0] core_rdata_o,
    output logic              core_ready_o,
    output logic              err_o,
    output logic [BUS_AW-1:0] err_addr_o,
    input  logic              err_clr_i
);

    localparam int          AW      = $clog2(DEPTH);
    // 33-bit bounds so a window ending at 0xFFFF_FFFF does not wrap
    localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI  = WIN_LO + 33'(4 * DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYC);

    function automatic logic in_window(input logic [BUS_AW-1:0] a);
        return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [BUS_AW-1:0] a);
        logic [BUS_AW-1:0] offset;
        offset = a - BASE_ADDR;
        return AW'(offset >> 2);
    endfunction

    resp_state_e       state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept;
    logic              ram_re;
    logic              ram_we;

    logic [BUS_AW-1:0] addr_p0;
    logic [BUS_DW-1:0] wdata_p0;
    logic [BUS_SW-1:0] wstrb_p0;

    logic [BUS_AW-1:0] dec_addr;
    logic              dec_in_win;
    logic [AW-1:0]     dec_idx;
    logic              is_resp;
    logic              is_read;
    logic [BUS_DW-1:0] ram_rdata_p1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            IDLE: begin
                if (core_valid_i) begin
                    accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_nxt = RESP;
                        ram_re    = 1'b1;
                    end else begin
                        cnt_nxt   = WAIT_LD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!core_valid_i) begin
                    // initiator withdrew the request: abort silently
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                    ram_re    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: request captured at accept, held through the response
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_p0  <= core_addr_i;
            wdata_p0 <= core_wdata_i;
            wstrb_p0 <= core_wstrb_i;
        end
    end

    // With zero wait states the read is issued in the accept cycle, before
    // the address has been captured, so the decoder looks at the live bus.
    assign dec_addr   = (state == IDLE) ? core_addr_i : addr_p0;
    assign dec_in_win = in_window(dec_addr);
    assign dec_idx    = word_idx(dec_addr);

    assign is_resp = (state == RESP);
    assign is_read = (wstrb_p0 == '0);
    assign ram_we  = is_resp && !rst_i && dec_in_win && !is_read;

    // ------------------------------------------------------------------
    // Stage p1: registered RAM read, valid in the response cycle
    // ------------------------------------------------------------------
    native_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .re    (ram_re),
        .be    (wstrb_p0),
        .idx   (dec_idx),
        .wdata (wdata_p0),
        .rdata (ram_rdata_p1)
    );

    assign core_ready_o = is_resp;
    assign core_rdata_o = (is_resp && is_read && dec_in_win) ? ram_rdata_p1 : '0;

    // Sticky error: a new error takes the address only when the flag was
    // clear or is being cleared in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (is_resp && !dec_in_win) begin
            err_o <= 1'b1;
            if (!err_o || err_clr_i) begin
                err_addr_o <= addr_p0;
            end
        end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end
    end

endmodule : native_ram_resp
